// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing constants.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to 1 (idle line).
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, one stop bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;
    logic                 par_ok;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_data),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    logic pbad_q, pbad_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
            pbad_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
            pbad_q <= pbad_d;
        end
    end

    // A frame that already flagged a parity error reports nothing further.
    assign par_ok     = !pbad_q;
    assign parity_err = perr_q;
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
        pbad_d  = pbad_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
`ifdef UART_RX_PARITY_EN
                pbad_d = 1'b0;
`endif
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StStop;
                    if (rx_s != ^shreg_q) begin
                        perr_d = 1'b1;
                        pbad_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
                        if (par_ok) begin
                            dout_d = shreg_q;
                            done_d = 1'b1;
                        end
                    end else begin
                        state_d = StWaitHigh;
                        ferr_d  = par_ok;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                if (rx_s) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout      = dout_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; honours UART_RX_PARITY_EN if defined.
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_data = 1'b1;
    logic [7:0] dout;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int pulse_bad = 0;
    int dout_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_lat = 0;
    logic [7:0] got_q[$];
    logic [7:0] prev_dout = 8'h00;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_perr = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .dout       (dout),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            done_lat = cyc - start_cyc;
            got_q.push_back(dout);
        end
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) pulse_bad++;
        if ((rx_done && prev_done) || (frame_err && prev_ferr) || (parity_err && prev_perr))
            pulse_bad++;
        if (rst_n && !rx_done && dout !== prev_dout) dout_bad++;
        prev_dout = dout;
        prev_done = rx_done;
        prev_ferr = frame_err;
        prev_perr = parity_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_time(input logic v);
        rx_data = v;
        tick(C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        start_cyc = cyc;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time(par);
`else
        if (par) begin end
`endif
        bit_time(stop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, f0, p0, q0;
        bit came_idle;

        // Reset state
        tick(3);
        check("rst_dout", dout, 8'h00);
        check("rst_done", rx_done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(5);

        // Single frame 0x55 with latency check
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, ^8'h55);
        tick(2);
        check("55_done", done_cnt - d0, 1);
        check("55_dout", dout, 8'h55);
        check("55_ferr", ferr_cnt - f0, 0);
        check("55_latency_ok", (done_lat >= 153 && done_lat <= 155), 1);
        check("55_idle", busy, 0);

        // Back-to-back 0xA3, 0x0F
        d0 = done_cnt; q0 = got_q.size();
        send_frame(8'hA3, 1'b1, ^8'hA3);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        tick(2);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_first", (got_q.size() > q0) ? got_q[q0] : 8'hxx, 8'hA3);
        check("b2b_second", (got_q.size() > q0 + 1) ? got_q[q0 + 1] : 8'hxx, 8'h0F);
        check("b2b_dout", dout, 8'h0F);

        // 4-cycle low glitch on idle line
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rx_data = 1'b0;
        tick(4);
        rx_data = 1'b1;
        came_idle = 1'b0;
        for (int i = 0; i < 12 && !came_idle; i++) begin
            tick(1);
            if (!busy) came_idle = 1'b1;
        end
        tick(C);
        check("glitch_idle", came_idle, 1);
        check("glitch_pulses", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);

        // Frame error: 0x3C with stop 0, line held low
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        tick(40 * C);
        check("ferr_count", ferr_cnt - f0, 1);
        check("ferr_done", done_cnt - d0, 0);
        check("ferr_dout", dout, 8'h0F);
        check("ferr_busy_low", busy, 1);
        rx_data = 1'b1;
        tick(4);
        check("ferr_busy_high", busy, 0);

        // Reset during bit 4 of 0xFF, then 0x81
        tick(C);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        tick(C / 2);
        rst_n = 1'b0;
        tick(3);
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_busy", busy, 0);
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rst_n = 1'b1;
        tick(4 * C);
        check("post_rst_quiet", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        send_frame(8'h81, 1'b1, ^8'h81);
        tick(2);
        check("81_done", done_cnt - d0, 1);
        check("81_dout", dout, 8'h81);

`ifdef UART_RX_PARITY_EN
        // Even parity of 0x07 is 1; send 0 first (wrong), then 1
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        tick(2);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_done", done_cnt - d0, 0);
        check("par_bad_ferr", ferr_cnt - f0, 0);
        check("par_bad_dout", dout, 8'h81);
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        tick(2);
        check("par_ok_done", done_cnt - d0, 1);
        check("par_ok_perr", perr_cnt - p0, 0);
        check("par_ok_dout", dout, 8'h07);
`else
        check("no_parity_err", perr_cnt, 0);
`endif

        check("pulse_shape", pulse_bad, 0);
        check("dout_stable", dout_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
